// File: rtl/vga_pkg.sv
// Shared constants for the VGA sprite controller: colour width, default 640x480@60 timing,
// named colours and the colour-bar helper used by the optional test pattern.
package vga_pkg;

  localparam int COLOR_W = 12;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam logic [COLOR_W-1:0] BLACK = 12'h000;
  localparam logic [COLOR_W-1:0] WHITE = 12'hFFF;
  localparam logic [COLOR_W-1:0] RED   = 12'hF00;
  localparam logic [COLOR_W-1:0] GREEN = 12'h0F0;
  localparam logic [COLOR_W-1:0] BLUE  = 12'h00F;

  // Bar k lights R,G,B from bits 2,1,0 of (7-k): bar 0 white, bar 7 black.
  function automatic logic [COLOR_W-1:0] bar_color(input logic [2:0] k);
    logic [2:0] m;
    m = 3'd7 - k;
    return {{4{m[2]}}, {4{m[1]}}, {4{m[0]}}};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider, raster h/v counters, sync/active decode and end-of-frame strobe.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hsync_act,
  output logic       vsync_act,
  output logic       active,
  output logic       frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  assign pix_tick = (div == DIV_LAST);

  // Clock-enable divider: one pixel tick every CLK_DIV clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= {DIV_W{1'b0}};
    end else if (pix_tick) begin
      div <= {DIV_W{1'b0}};
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Raster position: h runs along the line, v advances when h wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= 10'd0;
      v <= 10'd0;
    end else if (pix_tick) begin
      if (h == H_LAST) begin
        h <= 10'd0;
        v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  assign hsync_act = (h >= HS_START) && (h < HS_END);
  assign vsync_act = (v >= VS_START) && (v < VS_END);
  assign active    = (h < H_VIS) && (v < V_VIS);
  assign frame_end = pix_tick && (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/vga_sprite_controller.sv
// VGA timing plus fixed-priority square-sprite compositor with registered, aligned outputs.
// Build macro VGA_TEST_PATTERN_EN replaces the background colour with eight vertical colour bars.
module vga_sprite_controller
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = H_ACTIVE_DEF,
  parameter int   H_FP        = H_FP_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BP        = H_BP_DEF,
  parameter int   V_ACTIVE    = V_ACTIVE_DEF,
  parameter int   V_FP        = V_FP_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BP        = V_BP_DEF,
  parameter int   CLK_DIV     = 4,
  parameter int   NUM_SPRITES = 2,
  parameter int   SPRITE_SIZE = 20,
  parameter int   POS_W       = 10,
  parameter logic SYNC_POL    = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SPRITES*POS_W-1:0]   sprite_x,
  input  logic [NUM_SPRITES*POS_W-1:0]   sprite_y,
  input  logic [NUM_SPRITES*COLOR_W-1:0] sprite_color,
  input  logic [NUM_SPRITES-1:0]         sprite_en,
  input  logic [COLOR_W-1:0]             bg_color,
  output logic                           hsync,
  output logic                           vsync,
  output logic [COLOR_W-1:0]             rgb,
  output logic [9:0]                     h_counter,
  output logic [9:0]                     v_counter,
  output logic                           video_on,
  output logic                           frame_start
);

  // One bit of headroom over the widest coordinate so x+SPRITE_SIZE never wraps to 0.
  localparam int CMP_W = ((POS_W > 10) ? POS_W : 10) + 1;

  logic       pix_tick, hs_act, vs_act, active, frame_end;
  logic [9:0] h, v;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .pix_tick  (pix_tick),
    .h         (h),
    .v         (v),
    .hsync_act (hs_act),
    .vsync_act (vs_act),
    .active    (active),
    .frame_end (frame_end)
  );

  logic [NUM_SPRITES*POS_W-1:0]   lat_x, lat_y;
  logic [NUM_SPRITES*COLOR_W-1:0] lat_color;
  logic [NUM_SPRITES-1:0]         lat_en;
  logic [NUM_SPRITES-1:0]         hit;
  logic [COLOR_W-1:0]             base_color, pix_color;

  function automatic logic in_span(input logic [CMP_W-1:0] p, input logic [CMP_W-1:0] lo);
    return (p >= lo) && (p < lo + CMP_W'(SPRITE_SIZE));
  endfunction

  // Shadow sprite state, refreshed only at the last pixel of a frame to avoid tearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_x     <= {(NUM_SPRITES*POS_W){1'b0}};
      lat_y     <= {(NUM_SPRITES*POS_W){1'b0}};
      lat_color <= {(NUM_SPRITES*COLOR_W){1'b0}};
      lat_en    <= {NUM_SPRITES{1'b0}};
    end else if (frame_end) begin
      lat_x     <= sprite_x;
      lat_y     <= sprite_y;
      lat_color <= sprite_color;
      lat_en    <= sprite_en;
    end
  end

  // Per-sprite hit test against the current raster position.
  always_comb begin
    hit = {NUM_SPRITES{1'b0}};
    for (int i = 0; i < NUM_SPRITES; i++) begin
      hit[i] = lat_en[i]
             && in_span(CMP_W'(h), CMP_W'(lat_x[i*POS_W +: POS_W]))
             && in_span(CMP_W'(v), CMP_W'(lat_y[i*POS_W +: POS_W]));
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
  logic [9:0] bar_idx;
  assign bar_idx    = h / 10'(BAR_W);
  assign base_color = bar_color((bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0]);
`else
  assign base_color = bg_color;
`endif

  // Colour pick: walk from highest index down so the lowest-index hit wins; blank outside.
  always_comb begin
    pix_color = base_color;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      pix_color = hit[i] ? lat_color[i*COLOR_W +: COLOR_W] : pix_color;
    end
    pix_color = active ? pix_color : BLACK;
  end

  // Output stage: everything registered on the same tick so the outputs stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb         <= BLACK;
      h_counter   <= 10'd0;
      v_counter   <= 10'd0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && (h == 10'd0) && (v == 10'd0);
      if (pix_tick) begin
        rgb       <= pix_color;
        h_counter <= h;
        v_counter <= v;
        hsync     <= hs_act ? SYNC_POL : ~SYNC_POL;
        vsync     <= vs_act ? SYNC_POL : ~SYNC_POL;
        video_on  <= active;
      end
    end
  end

endmodule

// File: tb/tb_vga_sprite_controller.sv
// Bench for vga_sprite_controller on a reduced 14x7 raster; a tick-count raster model
// predicts every output on every clock, plus a table of hand-derived pixel expectations.
module tb_vga_sprite_controller;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 1;
  localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int DIV = 2, NS = 2, SS = 2, PW = 10;
  localparam int FRAME_CLK = HT * VT * DIV;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NS*PW-1:0]  sprite_x = '0;
  logic [NS*PW-1:0]  sprite_y = '0;
  logic [NS*12-1:0]  sprite_color = '0;
  logic [NS-1:0]     sprite_en = '0;
  logic [11:0]       bg_color = '0;
  logic              hsync, vsync, video_on, frame_start;
  logic [11:0]       rgb;
  logic [9:0]        h_counter, v_counter;

  vga_sprite_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(DIV), .NUM_SPRITES(NS), .SPRITE_SIZE(SS), .POS_W(PW), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_color(sprite_color),
    .sprite_en(sprite_en), .bg_color(bg_color),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .h_counter(h_counter), .v_counter(v_counter),
    .video_on(video_on), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int c = 0;
  bit latched = 1'b0, tick_now = 1'b0;
  int m_x[NS], m_y[NS];
  logic [11:0] m_col[NS];
  bit m_en[NS];
  int exp_h = 0, exp_v = 0;
  logic exp_hs = 1'b1, exp_vs = 1'b1, exp_von = 1'b0, exp_fs = 1'b0;
  logic [11:0] exp_rgb = 12'h000;

  typedef struct {
    string name;
    int x0, y0, x1, y1;
    logic [11:0] c0, c1;
    logic [1:0] en;
    logic [11:0] bg;
    int h, v;
    logic [11:0] exp_rgb;
    logic exp_von;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [11:0] model_color(input int hx, input int vy, input logic [11:0] bg);
    if (!(hx < HA && vy < VA)) return 12'h000;
    for (int i = 0; i < NS; i++) begin
      if (m_en[i] && hx >= m_x[i] && hx < m_x[i] + SS && vy >= m_y[i] && vy < m_y[i] + SS)
        return m_col[i];
    end
    return bg;
  endfunction

  // One clock: the model works out which pixel this edge registers purely from the edge count.
  task automatic step();
    int sx[NS], sy[NS];
    logic [11:0] scol[NS];
    bit sen[NS];
    logic [11:0] sbg;
    bit srst;
    int p;
    srst = reset;
    sbg  = bg_color;
    for (int i = 0; i < NS; i++) begin
      sx[i]   = int'(sprite_x[i*PW +: PW]);
      sy[i]   = int'(sprite_y[i*PW +: PW]);
      scol[i] = sprite_color[i*12 +: 12];
      sen[i]  = sprite_en[i];
    end
    @(posedge clk);
    #1;
    tick_now = 1'b0;
    if (srst) begin
      c = 0;
      for (int i = 0; i < NS; i++) begin
        m_x[i] = 0; m_y[i] = 0; m_col[i] = 12'h000; m_en[i] = 1'b0;
      end
      exp_h = 0; exp_v = 0; exp_hs = 1'b1; exp_vs = 1'b1;
      exp_von = 1'b0; exp_fs = 1'b0; exp_rgb = 12'h000;
    end else begin
      c++;
      exp_fs = 1'b0;
      if (c % DIV == 0) begin
        p = c / DIV - 1;
        tick_now = 1'b1;
        exp_h   = p % HT;
        exp_v   = (p / HT) % VT;
        exp_hs  = !(exp_h >= HA + HFP && exp_h < HA + HFP + HS);
        exp_vs  = !(exp_v >= VA + VFP && exp_v < VA + VFP + VS);
        exp_von = (exp_h < HA) && (exp_v < VA);
        exp_fs  = (exp_h == 0) && (exp_v == 0);
        exp_rgb = model_color(exp_h, exp_v, sbg);
        if (exp_h == HT - 1 && exp_v == VT - 1) begin
          for (int i = 0; i < NS; i++) begin
            m_x[i] = sx[i]; m_y[i] = sy[i]; m_col[i] = scol[i]; m_en[i] = sen[i];
          end
          latched = 1'b1;
        end
      end
    end
    chk("rgb", rgb, exp_rgb);
    chk("hsync", hsync, exp_hs);
    chk("vsync", vsync, exp_vs);
    chk("h_counter", h_counter, exp_h);
    chk("v_counter", v_counter, exp_v);
    chk("video_on", video_on, exp_von);
    chk("frame_start", frame_start, exp_fs);
  endtask

  task automatic set_inputs(input int x0, input int y0, input int x1, input int y1,
                            input logic [11:0] c0, input logic [11:0] c1,
                            input logic [1:0] en, input logic [11:0] bg);
    sprite_x     = {PW'(x1), PW'(x0)};
    sprite_y     = {PW'(y1), PW'(y0)};
    sprite_color = {c1, c0};
    sprite_en    = en;
    bg_color     = bg;
    latched      = 1'b0;
  endtask

  task automatic wait_latched();
    for (int k = 0; k < 2 * FRAME_CLK && !latched; k++) step();
    chk("latch_wait", latched, 1);
  endtask

  task automatic wait_pixel(input int hx, input int vy);
    bit found = 1'b0;
    for (int k = 0; k < 2 * FRAME_CLK && !found; k++) begin
      step();
      if (tick_now && exp_h == hx && exp_v == vy) found = 1'b1;
    end
    chk("pixel_wait", found, 1);
  endtask

  task automatic wait_fs();
    bit found = 1'b0;
    for (int k = 0; k < 2 * FRAME_CLK && !found; k++) begin
      step();
      if (frame_start === 1'b1) found = 1'b1;
    end
    chk("fs_wait", found, 1);
  endtask

  int cnt;
  int rx0, ry0, rx1, ry1;
  logic [13:0] hmask;
  logic [6:0]  vmask;

  initial begin
    tbl.push_back('{"in_3_1",     3, 1, 0, 0, 12'hF00, 12'h000, 2'b01, 12'h00F, 3, 1, 12'hF00, 1'b1});
    tbl.push_back('{"in_4_1",     3, 1, 0, 0, 12'hF00, 12'h000, 2'b01, 12'h00F, 4, 1, 12'hF00, 1'b1});
    tbl.push_back('{"in_3_2",     3, 1, 0, 0, 12'hF00, 12'h000, 2'b01, 12'h00F, 3, 2, 12'hF00, 1'b1});
    tbl.push_back('{"in_4_2",     3, 1, 0, 0, 12'hF00, 12'h000, 2'b01, 12'h00F, 4, 2, 12'hF00, 1'b1});
    tbl.push_back('{"left_2_1",   3, 1, 0, 0, 12'hF00, 12'h000, 2'b01, 12'h00F, 2, 1, 12'h00F, 1'b1});
    tbl.push_back('{"right_5_1",  3, 1, 0, 0, 12'hF00, 12'h000, 2'b01, 12'h00F, 5, 1, 12'h00F, 1'b1});
    tbl.push_back('{"below_3_3",  3, 1, 0, 0, 12'hF00, 12'h000, 2'b01, 12'h00F, 3, 3, 12'h00F, 1'b1});
    tbl.push_back('{"above_3_0",  3, 1, 0, 0, 12'hF00, 12'h000, 2'b01, 12'h00F, 3, 0, 12'h00F, 1'b1});
    tbl.push_back('{"prio_both",  3, 1, 3, 1, 12'hF00, 12'h0F0, 2'b11, 12'h00F, 3, 1, 12'hF00, 1'b1});
    tbl.push_back('{"prio_s1",    3, 1, 3, 1, 12'hF00, 12'h0F0, 2'b10, 12'h00F, 3, 1, 12'h0F0, 1'b1});
    tbl.push_back('{"s1_alone",   6, 2, 3, 1, 12'hF00, 12'h0F0, 2'b11, 12'h00F, 3, 1, 12'h0F0, 1'b1});
    tbl.push_back('{"corner_7_3", 6, 2, 3, 1, 12'hF00, 12'h0F0, 2'b11, 12'h00F, 7, 3, 12'hF00, 1'b1});
    tbl.push_back('{"xwrap_0_0", 1023, 0, 0, 0, 12'hF00, 12'h000, 2'b01, 12'h00F, 0, 0, 12'h00F, 1'b1});
    tbl.push_back('{"ywrap_0_0", 0, 1023, 0, 0, 12'hF00, 12'h000, 2'b01, 12'h00F, 0, 0, 12'h00F, 1'b1});
    tbl.push_back('{"hblank_9_1",  3, 1, 0, 0, 12'hF00, 12'h000, 2'b01, 12'h0F0, 9, 1, 12'h000, 1'b0});
    tbl.push_back('{"vblank_2_5",  3, 1, 0, 0, 12'hF00, 12'h000, 2'b01, 12'h0F0, 2, 5, 12'h000, 1'b0});
    tbl.push_back('{"blank_13_6",  3, 1, 0, 0, 12'hF00, 12'h000, 2'b01, 12'h0F0, 13, 6, 12'h000, 1'b0});

    // Reset state, then latency of the first frame_start after release.
    reset = 1'b1;
    step();
    step();
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_hv", {h_counter, v_counter}, 20'd0);
    reset = 1'b0;
    for (cnt = 1; cnt <= 10; cnt++) begin
      step();
      if (frame_start === 1'b1) break;
    end
    chk("first_fs_clk", cnt, 2);

    // Frame period and sync windows over one full frame.
    wait_fs();
    hmask = '0;
    vmask = '0;
    for (cnt = 1; cnt <= 2 * FRAME_CLK; cnt++) begin
      if (hsync === 1'b0 && h_counter < 10'd14) hmask[h_counter] = 1'b1;
      if (vsync === 1'b0 && v_counter < 10'd7)  vmask[v_counter] = 1'b1;
      step();
      if (frame_start === 1'b1) break;
    end
    chk("frame_period_clk", cnt, 196);
    chk("hsync_window", hmask, 14'h1C00);
    chk("vsync_window", vmask, 7'h20);

    // Table of single-pixel expectations.
    foreach (tbl[i]) begin
      set_inputs(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1,
                 tbl[i].c0, tbl[i].c1, tbl[i].en, tbl[i].bg);
      wait_latched();
      wait_pixel(tbl[i].h, tbl[i].v);
      chk(tbl[i].name, rgb, tbl[i].exp_rgb);
      chk({tbl[i].name, "_von"}, video_on, tbl[i].exp_von);
    end

    // Mid-frame move takes effect only from the next frame.
    set_inputs(3, 1, 0, 0, 12'hF00, 12'h000, 2'b01, 12'h00F);
    wait_latched();
    wait_pixel(0, 2);
    sprite_x = {PW'(0), PW'(5)};
    wait_pixel(3, 2);
    chk("tear_old_3_2", rgb, 12'hF00);
    wait_pixel(5, 2);
    chk("tear_old_5_2", rgb, 12'h00F);
    wait_pixel(3, 2);
    chk("tear_new_3_2", rgb, 12'h00F);
    wait_pixel(5, 2);
    chk("tear_new_5_2", rgb, 12'hF00);

    // Reset asserted mid-line.
    wait_pixel(5, 1);
    reset = 1'b1;
    step();
    chk("midrst_rgb", rgb, 12'h000);
    chk("midrst_sync", {hsync, vsync}, 2'b11);
    chk("midrst_hv", {h_counter, v_counter}, 20'd0);
    chk("midrst_von", video_on, 1'b0);
    reset = 1'b0;
    for (cnt = 1; cnt <= 10; cnt++) begin
      step();
      if (frame_start === 1'b1) break;
    end
    chk("midrst_fs_clk", cnt, 2);

    // Random sprite/background changes at random instants, checked by the model every clock.
    for (int r = 0; r < 24; r++) begin
      rx0 = ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 9));
      ry0 = int'($urandom_range(0, 5));
      rx1 = int'($urandom_range(0, 9));
      ry1 = ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 5));
      set_inputs(rx0, ry0, rx1, ry1, 12'($urandom), 12'($urandom),
                 2'($urandom), 12'($urandom));
      repeat ($urandom_range(1, 250)) step();
      if (r % 3 == 0) bg_color = 12'($urandom);
      repeat ($urandom_range(1, 60)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sprite_controller.md
Name: vga_sprite_controller

Overview:
- Parametrised successor to the single-player VGA controller.
- Generates standard VGA timing from a clock-enable pixel tick, with no derived clocks.
- Composites up to NUM_SPRITES fixed-priority square sprites over a background colour.
- Sits between the game-state logic (sprite positions and colours) and the board VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel; must be >=1; 1 means a tick every cycle
- NUM_SPRITES, 2, number of sprite channels, 1..8
- SPRITE_SIZE, 20, sprite edge length in pixels
- POS_W, 10, width of each sprite coordinate
- SYNC_POL, 0, active level of hsync/vsync; 0 means active-low

Ports:
- clk, input, 1, system clock
- reset, input, 1, synchronous, active-high
- sprite_x, input, NUM_SPRITES*POS_W, packed X positions; sprite i occupies bits [i*POS_W +: POS_W]
- sprite_y, input, NUM_SPRITES*POS_W, packed Y positions, same packing
- sprite_color, input, NUM_SPRITES*12, packed 12-bit RGB colours
- sprite_en, input, NUM_SPRITES, per-sprite visibility enable
- bg_color, input, 12, background colour
- hsync, output, 1, registered horizontal sync
- vsync, output, 1, registered vertical sync
- rgb, output, 12, registered pixel colour
- h_counter, output, 10, X of the pixel currently on rgb
- v_counter, output, 10, Y of the pixel currently on rgb
- video_on, output, 1, high while rgb is inside the active area
- frame_start, output, 1, one-clk pulse on the tick at which pixel (0,0) appears on rgb

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values:
  - divider = 0; internal h/v = 0
  - rgb = 0; h_counter = v_counter = 0
  - hsync = vsync = inactive (~SYNC_POL)
  - video_on = 0; frame_start = 0
  - latched sprite registers = 0, all sprites disabled
- Pixel tick:
  - The divider counts 0..CLK_DIV-1; pix_tick is high when divider == CLK_DIV-1.
  - All state except the divider advances only on pix_tick.
- Internal counters:
  - h wraps at H_TOTAL-1 = H_ACTIVE+H_FP+H_SYNC+H_BP-1 (default 799).
  - v increments when h wraps and itself wraps at V_TOTAL-1 (default 524).
- Output pipeline, one pixel tick of latency:
  - On each tick, the outputs register the values computed from the internal h/v.
  - h_counter, v_counter, rgb, hsync, vsync and video_on are therefore mutually aligned.
- Sync windows:
  - hsync is active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync is active for the same window on v.
- Active area: active = (h < H_ACTIVE) && (v < V_ACTIVE).
- Sprite hit for sprite i:
  - sprite_en[i] && x_i <= h < x_i+SPRITE_SIZE && y_i <= v < y_i+SPRITE_SIZE.
  - Compare at POS_W+1 bits so a sprite near the maximum coordinate does not wrap to the left or top edge.
- Colour selection:
  - Outside the active area rgb = 0.
  - Otherwise, the colour of the lowest-index hitting sprite.
  - Otherwise, bg_color.
- Tear-free sprite latch:
  - sprite_x, sprite_y, sprite_color and sprite_en are captured into shadow registers on the tick where internal h == H_TOTAL-1 and v == V_TOTAL-1.
  - Input changes mid-frame have no effect until the next frame.
- bg_color is sampled live, with no latch.
- frame_start is high for exactly one clk, on the tick that registers pixel (0,0); it is 0 at all other times.
- Reset asserted mid-frame: all state returns to reset values on the next clk edge. After reset deasserts, the first pixel (0,0) appears on the CLK_DIV-th cycle.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined: the background is replaced by 8 vertical colour bars, each H_ACTIVE/8 pixels wide. Bar k uses colour {R,G,B} = 4'hF for each set bit of (7-k) in the order R,G,B, and 0 otherwise; bar 0 is white and bar 7 is black. Sprites still overlay the bars.
- When undefined: bg_color is used and no bar logic is synthesised.

Decomposition:
- Package vga_pkg holds:
  - COLOR_W = 12
  - default 640x480@60 timing constants
  - named colour constants: BLACK, WHITE, RED, GREEN, BLUE
- Sub-module vga_timing_gen holds the divider, the h/v counters, the sync/active decode and the end-of-frame strobe.
- The top module holds the sprite shadow registers, hit/priority logic and output registers.

Test Plan:
- Bench parameters: small timing H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, CLK_DIV=2 -> H_TOTAL=14, V_TOTAL=7. Then check:
  - hsync is active for output h 10..12.
  - frame_start pulses every 196 clk.
  - vsync is active on v=5 only.
- Reset: pulse reset mid-line -> next edge gives rgb=0, sync inactive, h_counter=v_counter=0. The first frame_start appears 2 clk after release.
- Sprite boundaries:
  - Setup: SPRITE_SIZE=2, sprite0 at (3,1), color 12'hF00, bg 12'h00F.
  - Expect rgb=F00 at (3,1), (4,1), (3,2) and (4,2).
  - Expect rgb=00F at (2,1), (5,1) and (3,3).
- Priority: sprite0 (F00) and sprite1 (0F0) both at (3,1) -> F00; disable sprite0 -> 0F0.
- Tear-free latch: change sprite0 x from 3 to 5 while v=2 -> the rest of that frame still shows x=3; the next frame shows x=5.
- Edge and blanking:
  - Sprite at x=2^POS_W-1 -> no hit at h=0.
  - Any pixel in the blanking region -> rgb=0 and video_on=0, even when bg is nonzero.
